multicycle_controller: RTL and testbench

Main control unit for the multicycle RV32I-subset core. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives the ImmSrc select of the immediate extender, the datapath mux selects, the register/memory write enables and the ALU operation. The block sits between the instruction register (op/funct fields) and the shared datapath (PC, IR, ALU, register file, unified memory).

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 tb/tb_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle core control path: FSM states, opcodes,
// datapath mux selects, ALUOp and ALUControl values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Purpose: maps ALUOp plus instruction funct fields to an ALU operation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from I-type addi, whose bit 30 is immediate data
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: Moore FSM sequencing fetch/decode/execute/memory/writeback for the RV32I subset.
// Latency: 3-5 cycles per instruction (2 for an illegal op); selects are registered-state Moore.
// Backpressure: none; the FSM advances every cycle and reset aborts any instruction at once.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [2:0] ALUControl,
    output logic       instr_retire,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    state_t     state, state_nxt;
    logic [1:0] aluop;
    logic       irwrite_s, pcupdate, branch, regwrite_s, memwrite_s;
    logic       retire_s, illegal_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        irwrite_s  = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        retire_s   = 1'b0;
        illegal_s  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        aluop      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcupdate  = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALU;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target so BEQ can load it into the PC
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default: begin
                        state_nxt = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_IMM;
                state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEM;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_REG;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_REG;
                aluop     = ALUOP_SUB;
                branch    = 1'b1;
                retire_s  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_4;
                pcupdate  = 1'b1;
                state_nxt = S_ALUWB;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Enables are masked by rst_n directly so nothing writes while reset is held
    assign IRWrite       = irwrite_s & rst_n;
    assign PCWrite       = (pcupdate | (branch & zero)) & rst_n;
    assign RegWrite      = regwrite_s & rst_n;
    assign MemWrite      = memwrite_s & rst_n;
    assign instr_retire  = retire_s & rst_n;
    assign illegal_instr = illegal_s & rst_n;
    assign state_dbg     = state;

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction sequence model, plus pinned literal checks.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
    logic [2:0] ALUControl;
    logic       instr_retire, illegal_instr;
    logic [3:0] state_dbg;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ALUControl(ALUControl), .instr_retire(instr_retire),
        .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irw, pcu, br, rw, mw, adr;
        logic [1:0] a, b, res, aop;
        logic       ret, ill;
    } out_t;

    localparam int T_NONE = 0, T_RST = 1, T_LW = 2, T_SW = 3, T_RSUB = 4, T_RAND = 5;
    localparam int T_BEQ1 = 6, T_BEQ0 = 7, T_JAL = 8, T_ILL = 9;

    state_t exp_state;
    logic   chk_en = 1'b0;
    int     tag = T_NONE;
    int     idx = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    function automatic logic supported(input logic [6:0] o);
        return o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BEQ || o == OP_JAL;
    endfunction

    function automatic int seq_len(input logic [6:0] o);
        case (o)
            OP_LW:                     return 5;
            OP_SW, OP_R, OP_I, OP_JAL: return 4;
            OP_BEQ:                    return 3;
            default:                   return 2;
        endcase
    endfunction

    // Each instruction's state walk, written as a table of named steps.
    function automatic state_t state_at(input logic [6:0] o, input int i);
        state_t s [5];
        s[0] = S_FETCH; s[1] = S_DECODE; s[2] = S_FETCH; s[3] = S_FETCH; s[4] = S_FETCH;
        case (o)
            OP_LW:  begin s[2] = S_MEMADR;   s[3] = S_MEMREAD; s[4] = S_MEMWB; end
            OP_SW:  begin s[2] = S_MEMADR;   s[3] = S_MEMWRITE; end
            OP_R:   begin s[2] = S_EXECUTER; s[3] = S_ALUWB; end
            OP_I:   begin s[2] = S_EXECUTEI; s[3] = S_ALUWB; end
            OP_BEQ: s[2] = S_BEQ;
            OP_JAL: begin s[2] = S_JAL;      s[3] = S_ALUWB; end
            default: ;
        endcase
        return s[i];
    endfunction

    function automatic out_t exp_out(input state_t s, input logic [6:0] o);
        out_t e = '0;
        case (s)
            S_FETCH:    begin e.irw = 1; e.b = 2'b10; e.res = 2'b10; e.pcu = 1; end
            S_DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.ill = !supported(o); end
            S_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
            S_MEMREAD:  e.adr = 1;
            S_MEMWB:    begin e.res = 2'b01; e.rw = 1; e.ret = 1; end
            S_MEMWRITE: begin e.adr = 1; e.mw = 1; e.ret = 1; end
            S_EXECUTER: begin e.a = 2'b10; e.aop = 2'b10; end
            S_EXECUTEI: begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
            S_ALUWB:    begin e.rw = 1; e.ret = 1; end
            S_BEQ:      begin e.a = 2'b10; e.aop = 2'b01; e.br = 1; e.ret = 1; end
            S_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pcu = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int alu_ref(input logic [1:0] aop, input logic [2:0] f3, input logic o5, input logic f7);
        if (aop == 2'b00) return 0;
        if (aop == 2'b01) return 1;
        case (f3)
            3'b000:  return (o5 && f7) ? 1 : 0;
            3'b010:  return 5;
            3'b110:  return 3;
            3'b111:  return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int imm_ref(input logic [6:0] o);
        if (o == OP_SW)  return 1;
        if (o == OP_BEQ) return 2;
        if (o == OP_JAL) return 3;
        return 0;
    endfunction

    // Model comparison on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            out_t e;
            logic on;
            e  = exp_out(exp_state, op);
            on = rst_n;
            chk("state_dbg", state_dbg, exp_state);
            chk("IRWrite", IRWrite, e.irw & on);
            chk("PCWrite", PCWrite, (e.pcu | (e.br & zero)) & on);
            chk("RegWrite", RegWrite, e.rw & on);
            chk("MemWrite", MemWrite, e.mw & on);
            chk("instr_retire", instr_retire, e.ret & on);
            chk("illegal_instr", illegal_instr, e.ill & on);
            chk("AdrSrc", AdrSrc, e.adr);
            chk("ALUSrcA", ALUSrcA, e.a);
            chk("ALUSrcB", ALUSrcB, e.b);
            chk("ResultSrc", ResultSrc, e.res);
            chk("ALUControl", ALUControl, alu_ref(e.aop, funct3, op[5], funct7b5));
            chk("ImmSrc", ImmSrc, imm_ref(op));
        end
    end

    // Hand-computed literal expectations pinning the model
    always @(negedge clk) begin
        int lw_lit [5];
        lw_lit[0] = 0; lw_lit[1] = 1; lw_lit[2] = 2; lw_lit[3] = 3; lw_lit[4] = 4;
        case (tag)
            T_RST: begin
                chk("lit_rst_state", state_dbg, 0);
                chk("lit_rst_en", {IRWrite, PCWrite, RegWrite, MemWrite}, 0);
            end
            T_LW: begin
                chk("lit_lw_state", state_dbg, lw_lit[idx]);
                chk("lit_lw_regwrite", RegWrite, (idx == 4) ? 1 : 0);
                chk("lit_lw_imm", ImmSrc, 0);
            end
            T_SW: begin
                chk("lit_sw_memwrite", MemWrite, (idx == 3) ? 1 : 0);
                chk("lit_sw_imm", ImmSrc, 1);
                if (idx == 3) chk("lit_sw_adrsrc", AdrSrc, 1);
            end
            T_RSUB: if (idx == 2) chk("lit_rsub_aluctl", ALUControl, 1);
            T_RAND: begin
                if (idx == 2) chk("lit_rand_aluctl", ALUControl, 2);
                if (idx == 3) chk("lit_rand_regwrite", RegWrite, 1);
            end
            T_BEQ1: if (idx == 2) begin
                chk("lit_beq1_pcwrite", PCWrite, 1);
                chk("lit_beq1_retire", instr_retire, 1);
                chk("lit_beq1_imm", ImmSrc, 2);
            end
            T_BEQ0: if (idx == 2) chk("lit_beq0_pcwrite", PCWrite, 0);
            T_JAL: begin
                chk("lit_jal_imm", ImmSrc, 3);
                if (idx == 0 || idx == 2) chk("lit_jal_pcwrite", PCWrite, 1);
                if (idx == 2) chk("lit_jal_srcs", {ALUSrcA, ALUSrcB}, 4'b0110);
                if (idx == 3) chk("lit_jal_regwrite", RegWrite, 1);
            end
            T_ILL: if (idx == 1) begin
                chk("lit_ill_pulse", illegal_instr, 1);
                chk("lit_ill_en", {RegWrite, MemWrite, PCWrite, IRWrite}, 0);
            end
            default: ;
        endcase
    end

    // Called at the start of a cycle in which the DUT sits in FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int t, input int abort_at);
        for (int i = 0; i < seq_len(o); i++) begin
            if (i == 0) begin
                op = o; funct3 = f3; funct7b5 = f7;
            end
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            if (i == abort_at) begin
                tag = T_NONE;
                rst_n = 1'b0;
                exp_state = S_FETCH;
                repeat (2) begin @(posedge clk); #1; end
                rst_n = 1'b1;
                return;
            end
            exp_state = state_at(o, i);
            idx = i;
            tag = t;
            @(posedge clk); #1;
        end
        tag = T_NONE;
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [6:0] o;
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
        ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;

        rst_n = 1'b0; op = OP_LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        exp_state = S_FETCH;
        chk_en = 1'b1;
        tag = T_RST;
        repeat (3) @(posedge clk);
        #1;
        tag = T_NONE;
        rst_n = 1'b1;

        run_instr(OP_LW,  3'b010, 1'b0, 0, T_LW,   -1);
        run_instr(OP_SW,  3'b010, 1'b0, 0, T_SW,   -1);
        run_instr(OP_R,   3'b000, 1'b1, 0, T_RSUB, -1);
        run_instr(OP_R,   3'b111, 1'b0, 0, T_RAND, -1);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1, T_BEQ1, -1);
        run_instr(OP_BEQ, 3'b000, 1'b0, 0, T_BEQ0, -1);
        run_instr(OP_JAL, 3'b000, 1'b0, 0, T_JAL,  -1);
        run_instr(7'b0000000, 3'b000, 1'b0, 0, T_ILL, -1);
        run_instr(OP_LW,  3'b010, 1'b0, 0, T_NONE, 3);
        run_instr(OP_LW,  3'b010, 1'b0, 0, T_LW,   -1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                o = 7'($urandom);
                if (supported(o)) o = 7'b1111111;
            end else begin
                o = ops[$urandom_range(0, 5)];
            end
            run_instr(o, 3'($urandom), 1'($urandom), 2, T_NONE,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
